board_ram_scheduler: RTL and testbench
======================================

# board_ram_scheduler

Single-port arbiter and sequencer for the 5x5 minesweeper board-status RAM. The VGA renderer's per-pixel cell lookup shares the port with the game-logic read/write requester. VGA reads get priority during active display, backed by a one-entry cell cache and a starvation guard. Game accesses use a req/ack handshake. The block sits between the VGA controller, the game core and the board RAM instance.

## Interface
- CELLS, 25, number of board cells; legal addresses 0..CELLS-1
- ADDR_WIDTH, 5, RAM address width
- DATA_WIDTH, 32, RAM word width; cell status in bits [3:0]
- STARVE_LIMIT, 8, consecutive denied game-wait cycles before a forced game grant
- clk  in  1  system clock (50 MHz)
- reset  in  1  synchronous, active-low reset
- vga_active  in  1  VGA timing generator is in the active region
- vga_valid  in  1  current pixel lies on a board cell (not background)
- vga_addr  in  10  cell ID of current pixel
- vga_data  out  DATA_WIDTH  status word for the most recently resolved VGA cell
- game_req  in  1  game access request; held until ack
- game_we  in  1  1 = write, 0 = read; held with req
- game_addr  in  ADDR_WIDTH  game cell address; held with req
- game_wdata  in  DATA_WIDTH  write data; held with req
- game_ack  out  1  one-cycle completion pulse
- game_rdata  out  DATA_WIDTH  read data, valid in the ack cycle and held afterwards
- ram_addr  out  ADDR_WIDTH  RAM address
- ram_we  out  1  RAM write enable
- ram_wdata  out  DATA_WIDTH  RAM write data
- ram_rdata  in  DATA_WIDTH  RAM read data, 1-cycle synchronous read latency

## Operation
- VGA lookup is needed when vga_active && vga_valid && vga_addr < CELLS.
- Cell cache holds {cache_valid, cache_addr}.
  - Hit: lookup needed, cache_valid, and cache_addr == vga_addr. No RAM access; vga_data is unchanged.
  - Miss: lookup needed and not a hit. This requires a VGA RAM read.
- Game FSM has three states:
  - IDLE: game_req=1 moves to ISSUE when granted.
  - ISSUE: the RAM access was driven this cycle; always moves to RESP.
  - RESP: game_ack=1; game_rdata <= ram_rdata on a read. Returns to IDLE.
- Grant, decided combinationally each cycle:
  - Miss and starve_cnt < STARVE_LIMIT: VGA is granted.
  - Otherwise, game_req and FSM in IDLE: game is granted.
  - Otherwise: no access (ram_we=0).
- starve_cnt increments while FSM is IDLE, game_req=1 and the game is denied. It saturates at STARVE_LIMIT and clears on a game grant.
- VGA grant in cycle N:
  - ram_addr=vga_addr[ADDR_WIDTH-1:0], ram_we=0.
  - cache_addr <= vga_addr at N; cache_valid <= 1 at N+1 together with vga_data <= ram_rdata.
  - While the fill is pending, a lookup at the same address counts as a hit.
- Game grant: ram_addr=game_addr, ram_we=game_we, ram_wdata=game_wdata.
- Out-of-range game_addr (>= CELLS): no RAM access (ram_we=0), but the FSM still runs IDLE→ISSUE→RESP. game_rdata=0 on a read.
- A game write to cache_addr while cache_valid is handled according to Configuration.
- vga_active falling clears cache_valid, so each frame starts fresh.

## Timing
- Reset values (reset low at a clk edge): vga_data=0, game_ack=0, game_rdata=0, cache_valid=0, cache_addr=0, starve_cnt=0, FSM=IDLE.
- Combinational ram_* outputs are 0 while reset is held.
- VGA latency: vga_addr presented in cycle N (miss, granted) gives vga_data valid at cycle N+2.
- Game latency: the minimum is granted cycle N, ISSUE at N+1, ack at N+2.
  - Requester may change inputs or drop req in the cycle after ack.
  - The FSM samples req again only in IDLE, so the earliest back-to-back grant is the cycle after ack.
- Simultaneous VGA miss and game request: VGA wins unless starve_cnt == STARVE_LIMIT.
- Worst-case game wait: STARVE_LIMIT+1 cycles from req to grant.
- Reset asserted mid-transaction: the transaction is abandoned and no ack is issued. A write already driven to the RAM is not undone.

## Configuration
- BOARD_SCHED_FWD_EN defined: a game write hitting cache_addr with cache_valid updates vga_data <= game_wdata in the ISSUE cycle. The cache stays valid and no VGA re-read occurs.
- BOARD_SCHED_FWD_EN undefined: the same write clears cache_valid in the ISSUE cycle. The next VGA lookup misses and re-reads the RAM.

## Test plan
- Reset low for 3 cycles with game_req=1: all outputs 0, no ack. Release: ack at grant+2.
- vga_active=1, vga_valid=1, vga_addr=7, RAM[7]=4'd3: exactly one ram read of address 7. vga_data=3 two cycles later; no further RAM reads while vga_addr stays 7.
- VGA address changes every cycle (forced misses) with game read of cell 12 pending: game granted on the 9th waiting cycle (STARVE_LIMIT=8); ack 2 cycles later with RAM[12].
- Game write cell 7 = 9 while VGA cached at 7:
  - With FWD_EN: vga_data=9 after ISSUE and no RAM read.
  - Without FWD_EN: RAM re-read of 7, and vga_data=9 two cycles after the write's ISSUE cycle.
- Game read addr 30: no RAM access; ack after 2 cycles with game_rdata=0.
- vga_active=0 with back-to-back game reads of cells 0..24: each acked 2 cycles after grant, grants 3 cycles apart, data matches RAM.

Source files
------------

// File: rtl/board_ram_scheduler_if.sv
// -----------------------------------------------------------------------------
// board_ram_scheduler_if
//
// Purpose : request/acknowledge bus between the game core (master) and the
//           board RAM scheduler (slave).
//
// Signals :
//   req    master->slave  access request, held until ack
//   we     master->slave  1 = write, 0 = read, held with req
//   addr   master->slave  board cell address, held with req
//   wdata  master->slave  write data, held with req
//   ack    slave->master  one-cycle completion pulse
//   rdata  slave->master  read data, valid in the ack cycle and held afterwards
// -----------------------------------------------------------------------------
interface board_ram_scheduler_if #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
);

  logic                  req;
  logic                  we;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] wdata;
  logic                  ack;
  logic [DATA_WIDTH-1:0] rdata;

  modport master (
    output req,
    output we,
    output addr,
    output wdata,
    input  ack,
    input  rdata
  );

  modport slave (
    input  req,
    input  we,
    input  addr,
    input  wdata,
    output ack,
    output rdata
  );

endinterface : board_ram_scheduler_if

// File: rtl/board_ram_scheduler.sv
// -----------------------------------------------------------------------------
// board_ram_scheduler
//
// Purpose : arbitrates the single port of the 5x5 minesweeper board-status RAM
//           between the VGA renderer's per-pixel cell lookup and the game
//           core's read/write requests. VGA lookups win during active display,
//           filtered through a one-entry cell cache; a starvation counter
//           forces a game grant after STARVE_LIMIT denied cycles.
//
// Ports :
//   clk           system clock
//   reset         synchronous, active-low reset
//   vga_active_i  timing generator is in the active region
//   vga_valid_i   current pixel lies on a board cell
//   vga_addr_i    cell ID of the current pixel (10 bits)
//   vga_data_o    status word of the most recently resolved VGA cell
//   game_s        game req/ack bus (board_ram_scheduler_if.slave)
//   ram_addr_o    RAM address            (combinational, 0 in reset)
//   ram_we_o      RAM write enable       (combinational, 0 in reset)
//   ram_wdata_o   RAM write data         (combinational, 0 in reset)
//   ram_rdata_i   RAM read data, one-cycle synchronous read latency
//
// Build option :
//   BOARD_SCHED_FWD_EN  defined   -> a game write that hits the cached cell
//                                    forwards its data straight into vga_data
//                       undefined -> the same write invalidates the cache entry
//                                    so the next lookup re-reads the RAM
// -----------------------------------------------------------------------------
module board_ram_scheduler #(
  parameter int CELLS        = 25,
  parameter int ADDR_WIDTH   = 5,
  parameter int DATA_WIDTH   = 32,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                  clk,
  input  logic                  reset,

  input  logic                  vga_active_i,
  input  logic                  vga_valid_i,
  input  logic [9:0]            vga_addr_i,
  output logic [DATA_WIDTH-1:0] vga_data_o,

  board_ram_scheduler_if.slave  game_s,

  output logic [ADDR_WIDTH-1:0] ram_addr_o,
  output logic                  ram_we_o,
  output logic [DATA_WIDTH-1:0] ram_wdata_o,
  input  logic [DATA_WIDTH-1:0] ram_rdata_i
);

  // ---------------------------------------------------------------------------
  // Local constants and types
  // ---------------------------------------------------------------------------
  localparam int          STARVE_W   = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [31:0] CELLS_U    = CELLS;
  localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } game_state_e;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  game_state_e           state_q;
  logic                  game_ack_q;
  logic [DATA_WIDTH-1:0] game_rdata_q;

  logic                  cache_valid_q;
  logic [ADDR_WIDTH-1:0] cache_addr_q;
  logic                  fill_pending_q;  // VGA read issued last cycle, data on ram_rdata_i now
  logic [DATA_WIDTH-1:0] vga_data_q;
  logic [STARVE_W-1:0]   starve_cnt_q;

  // ---------------------------------------------------------------------------
  // Request decode
  // ---------------------------------------------------------------------------
  logic vga_in_range;
  logic game_in_range;
  logic vga_lookup;
  logic vga_addr_match;
  logic wr_issue_hit;
  logic cache_live;
  logic vga_hit;
  logic vga_miss;
  logic vga_grant;
  logic game_grant;

  assign vga_in_range   = 32'(vga_addr_i) < CELLS_U;
  assign game_in_range  = 32'(game_s.addr) < CELLS_U;
  assign vga_lookup     = vga_active_i && vga_valid_i && vga_in_range;
  assign vga_addr_match = 32'(vga_addr_i) == 32'(cache_addr_q);

  // The game access was performed in the grant cycle, so by the ISSUE cycle the
  // RAM already holds the new word. The request fields are still held stable
  // by the requester until ack, so they can be used here directly.
  assign wr_issue_hit = (state_q == ST_ISSUE) && game_s.we && game_in_range &&
                        cache_valid_q && (game_s.addr == cache_addr_q);

`ifdef BOARD_SCHED_FWD_EN
  // The written word is forwarded into vga_data at the end of ISSUE, so the
  // entry stays usable throughout.
  assign cache_live = cache_valid_q;
`else
  // Invalidate already within the ISSUE cycle: a lookup of that cell misses
  // immediately and re-reads the freshly written word, giving new vga_data two
  // cycles after ISSUE.
  assign cache_live = cache_valid_q && !wr_issue_hit;
`endif

  // A fill in flight for the same cell counts as a hit: the data is already on
  // its way and a second read would only waste a RAM slot.
  assign vga_hit    = vga_lookup && vga_addr_match && (cache_live || fill_pending_q);
  assign vga_miss   = vga_lookup && !vga_hit;
  assign vga_grant  = vga_miss && (starve_cnt_q < STARVE_MAX);
  assign game_grant = !vga_grant && game_s.req && (state_q == ST_IDLE);

  // ---------------------------------------------------------------------------
  // RAM port drive
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every output gets a default before any branch; a path that leaves
    // one unassigned would infer a latch.
    ram_addr_o  = '0;
    ram_we_o    = 1'b0;
    ram_wdata_o = '0;
    if (reset) begin
      if (vga_grant) begin
        ram_addr_o = vga_addr_i[ADDR_WIDTH-1:0];
      end else if (game_grant && game_in_range) begin
        // Out-of-range game cells still run the handshake but never touch RAM.
        ram_addr_o  = game_s.addr;
        ram_we_o    = game_s.we;
        ram_wdata_o = game_s.wdata;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Game FSM with registered ack / read data
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      game_ack_q   <= 1'b0;
      game_rdata_q <= '0;
    end else begin
      // NOTE: state registers use non-blocking assignments so every flop
      // samples the pre-edge values, independent of statement order.
      game_ack_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (game_grant) begin
            state_q <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          // ram_rdata_i now carries the word read in the grant cycle; latching
          // it here makes it visible together with ack in RESP.
          state_q    <= ST_RESP;
          game_ack_q <= 1'b1;
          if (!game_s.we) begin
            game_rdata_q <= game_in_range ? ram_rdata_i : '0;
          end
        end
        ST_RESP: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Cell cache, VGA data and starvation counter
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset) begin
      // NOTE: the cache is a single register entry, not a memory array, so it
      // is reset completely; a stale valid bit would return garbage pixels.
      cache_valid_q  <= 1'b0;
      cache_addr_q   <= '0;
      fill_pending_q <= 1'b0;
      vga_data_q     <= '0;
      starve_cnt_q   <= '0;
    end else begin
      fill_pending_q <= vga_grant;

      if (vga_grant) begin
        cache_addr_q <= vga_addr_i[ADDR_WIDTH-1:0];
      end

      // Fill data wins over a forwarded write; the two never coincide because
      // a game grant excludes a VGA grant in the same cycle.
`ifdef BOARD_SCHED_FWD_EN
      if (fill_pending_q) begin
        vga_data_q <= ram_rdata_i;
      end else if (wr_issue_hit) begin
        vga_data_q <= game_s.wdata;
      end
`else
      if (fill_pending_q) begin
        vga_data_q <= ram_rdata_i;
      end
`endif

      // Holding the entry invalid for the whole blanking interval is
      // equivalent to clearing it on the falling edge: no lookup can happen
      // until vga_active_i returns, so every frame starts with a cold cache.
      if (!vga_active_i) begin
        cache_valid_q <= 1'b0;
      end else if (vga_grant) begin
        // The entry now names the new cell; fill_pending_q covers it until
        // the data lands.
        cache_valid_q <= 1'b0;
      end else if (fill_pending_q) begin
        cache_valid_q <= 1'b1;
      end else if (wr_issue_hit) begin
        cache_valid_q <= cache_live;
      end

      if (game_grant) begin
        starve_cnt_q <= '0;
      end else if ((state_q == ST_IDLE) && game_s.req && (starve_cnt_q < STARVE_MAX)) begin
        starve_cnt_q <= starve_cnt_q + STARVE_W'(1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign vga_data_o   = vga_data_q;
  assign game_s.ack   = game_ack_q;
  assign game_s.rdata = game_rdata_q;

endmodule : board_ram_scheduler

// File: tb/tb_board_ram_scheduler.sv
// -----------------------------------------------------------------------------
// tb_board_ram_scheduler
//
// Self-checking bench for board_ram_scheduler. A behavioural RAM sits on the
// RAM port; expected values come from a shadow copy of the board contents that
// the bench updates from its own game writes. Directed phases cover reset, the
// VGA cache, starvation, write coherence, out-of-range access and back-to-back
// throughput; a randomized phase mixes random game traffic with random VGA
// activity and probes cache coherence afterwards.
// -----------------------------------------------------------------------------
module tb_board_ram_scheduler;

  localparam int CELLS = 25;
  localparam int AW    = 5;
  localparam int DW    = 32;
  localparam int SL    = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          vga_active;
  logic          vga_valid;
  logic [9:0]    vga_addr;
  logic [DW-1:0] vga_data;
  logic [AW-1:0] ram_addr;
  logic          ram_we;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata;

  always #10 clk = ~clk;

  board_ram_scheduler_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) game_if ();

  board_ram_scheduler #(
    .CELLS        (CELLS),
    .ADDR_WIDTH   (AW),
    .DATA_WIDTH   (DW),
    .STARVE_LIMIT (SL)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .vga_active_i (vga_active),
    .vga_valid_i  (vga_valid),
    .vga_addr_i   (vga_addr),
    .vga_data_o   (vga_data),
    .game_s       (game_if),
    .ram_addr_o   (ram_addr),
    .ram_we_o     (ram_we),
    .ram_wdata_o  (ram_wdata),
    .ram_rdata_i  (ram_rdata)
  );

  // ---------------------------------------------------------------------------
  // Board RAM model: one-cycle synchronous read, preloaded while reset is low
  // ---------------------------------------------------------------------------
  function automatic logic [31:0] init_word(input int i);
    if (i == 7) return 32'd3;
    return 32'hC0DE_0000 | 32'(i * 37 + 1);
  endfunction

  logic [DW-1:0] mem [32];

  always @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < 32; i++) mem[i] <= init_word(i);
    end else if (ram_we) begin
      mem[ram_addr] <= ram_wdata;
    end
    ram_rdata <= mem[ram_addr];
  end

  // ---------------------------------------------------------------------------
  // Bookkeeping
  // ---------------------------------------------------------------------------
  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  always @(posedge clk) cyc <= cyc + 1;

  logic [DW-1:0] shadow [32];  // expected board contents

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Random VGA activity, enabled only while the bench is not steering VGA.
  bit vga_rand = 1'b0;

  always @(posedge clk) begin
    if (vga_rand) begin
      #1;
      vga_active = ($urandom_range(0, 7) != 0);
      vga_valid  = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 1) == 1) vga_addr = 10'($urandom_range(0, 31));
    end
  end

  // One game transaction: raise req, wait (bounded) for ack, drop req the
  // cycle after ack. lat = cycles from req to ack, gnt = first cycle the RAM
  // port shows this access, acc = cycles with any visible RAM activity.
  task automatic game_xact(input logic we, input logic [AW-1:0] addr,
                           input logic [DW-1:0] wd, output int lat,
                           output int gnt, output int acc,
                           output logic [DW-1:0] rd);
    game_if.req   = 1'b1;
    game_if.we    = we;
    game_if.addr  = addr;
    game_if.wdata = wd;
    lat = 0;
    gnt = -1;
    acc = 0;
    while (1) begin
      @(negedge clk);
      if (ram_we || ram_addr != '0) acc++;
      if (gnt < 0 && ram_addr == addr && ram_we == we && (!we || ram_wdata == wd)) gnt = cyc;
      if (game_if.ack) break;
      if (lat >= 40) begin
        check("ack_timeout", 64'(lat), 64'(SL + 2));
        break;
      end
      next_cycle();
      lat++;
    end
    rd = game_if.rdata;
    next_cycle();
    game_if.req = 1'b0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  int            lat, gnt, acc, c0, prev_gnt, gk, ak, rd7, pa;
  logic [DW-1:0] rd, v2, v3, wd, exp_rd;
  logic [AW-1:0] a;
  logic          we;

  initial begin
    reset         = 1'b0;
    vga_active    = 1'b0;
    vga_valid     = 1'b0;
    vga_addr      = '0;
    game_if.req   = 1'b1;  // request held through reset: must be ignored
    game_if.we    = 1'b0;
    game_if.addr  = 5'd5;
    game_if.wdata = '0;
    for (int i = 0; i < 32; i++) shadow[i] = init_word(i);

    // --- Reset ---------------------------------------------------------------
    next_cycle();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("rst_ram_we",    64'(ram_we),       64'(0));
      check("rst_ram_addr",  64'(ram_addr),     64'(0));
      check("rst_ram_wdata", 64'(ram_wdata),    64'(0));
      check("rst_ack",       64'(game_if.ack),  64'(0));
      check("rst_vga_data",  64'(vga_data),     64'(0));
      check("rst_rdata",     64'(game_if.rdata), 64'(0));
      next_cycle();
    end
    reset = 1'b1;
    c0 = cyc;
    game_xact(1'b0, 5'd5, '0, lat, gnt, acc, rd);
    check("rel_grant_cycle", 64'(gnt), 64'(c0));
    check("rel_ack_latency", 64'(lat), 64'(2));
    check("rel_rdata",       64'(rd),  64'(shadow[5]));

    // --- VGA miss then hits at cell 7 -----------------------------------------
    vga_active = 1'b1;
    vga_valid  = 1'b1;
    vga_addr   = 10'd7;
    rd7 = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (ram_addr == 5'd7 && !ram_we) rd7++;
      if (k == 0) check("vga_read_addr", 64'(ram_addr), 64'(7));
      if (k == 1) check("vga_before_fill", 64'(vga_data), 64'(0));
      if (k == 2) check("vga_fill_7", 64'(vga_data), 64'(shadow[7]));
      next_cycle();
    end
    check("vga_reads_7", 64'(rd7), 64'(1));

    // --- Starvation: VGA misses every cycle, game reads cell 12 --------------
    vga_addr      = 10'd1;
    game_if.req   = 1'b1;
    game_if.we    = 1'b0;
    game_if.addr  = 5'd12;
    gk = -1;
    ak = -1;
    rd = '0;
    for (int k = 0; k < 24; k++) begin
      @(negedge clk);
      if (gk < 0 && ram_addr == 5'd12 && !ram_we) gk = k;
      if (game_if.ack) begin
        ak = k;
        rd = game_if.rdata;
        break;
      end
      next_cycle();
      vga_addr = (vga_addr == 10'd1) ? 10'd2 : 10'd1;
    end
    check("starve_grant_cycle", 64'(gk), 64'(SL));
    check("starve_ack_cycle",   64'(ak), 64'(SL + 2));
    check("starve_rdata",       64'(rd), 64'(shadow[12]));
    next_cycle();
    game_if.req = 1'b0;

    // --- Game write to the cached cell 7 --------------------------------------
    vga_addr = 10'd7;
    repeat (4) next_cycle();
    game_if.req   = 1'b1;
    game_if.we    = 1'b1;
    game_if.addr  = 5'd7;
    game_if.wdata = 32'd9;
    gk = -1;
    ak = -1;
    rd7 = 0;
    v2 = '0;
    v3 = '0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (gk < 0 && ram_we && ram_addr == 5'd7) gk = k;
      else if (gk >= 0 && !ram_we && ram_addr == 5'd7) rd7++;
      if (gk >= 0 && k == gk + 2) v2 = vga_data;
      if (gk >= 0 && k == gk + 3) v3 = vga_data;
      if (game_if.ack && ak < 0) ak = k;
      next_cycle();
      if (ak >= 0) game_if.req = 1'b0;
    end
    shadow[7] = 32'd9;
    game_if.we = 1'b0;
    check("wr7_grant_cycle", 64'(gk), 64'(0));
    check("wr7_ack_cycle",   64'(ak), 64'(2));
    check("wr7_vga_issue_p2", 64'(v3), 64'(9));
`ifdef BOARD_SCHED_FWD_EN
    check("wr7_fwd_vga_issue_p1", 64'(v2), 64'(9));
    check("wr7_fwd_rereads",      64'(rd7), 64'(0));
`else
    check("wr7_inv_rereads",      64'(rd7), 64'(1));
`endif

    // --- Out-of-range game read ----------------------------------------------
    vga_active = 1'b0;
    game_xact(1'b0, 5'd30, '0, lat, gnt, acc, rd);
    check("oob_ack_latency", 64'(lat), 64'(2));
    check("oob_ram_activity", 64'(acc), 64'(0));
    check("oob_rdata", 64'(rd), 64'(0));

    // --- Back-to-back reads of every cell with VGA idle ----------------------
    prev_gnt = 0;
    for (int k = 0; k < CELLS; k++) begin
      game_xact(1'b0, AW'(k), '0, lat, gnt, acc, rd);
      check($sformatf("b2b_lat_%0d", k),   64'(lat), 64'(2));
      check($sformatf("b2b_rdata_%0d", k), 64'(rd),  64'(shadow[k]));
      if (k > 0) check($sformatf("b2b_spacing_%0d", k), 64'(gnt - prev_gnt), 64'(3));
      prev_gnt = gnt;
    end

    // --- Randomized game traffic against random VGA activity -----------------
    for (int it = 0; it < 150; it++) begin
      vga_rand = 1'b1;
      we = 1'($urandom_range(0, 1));
      a  = ($urandom_range(0, 7) == 0) ? AW'(25 + $urandom_range(0, 6))
                                       : AW'($urandom_range(0, CELLS - 1));
      wd = $urandom;
      game_xact(we, a, wd, lat, gnt, acc, rd);
      vga_rand = 1'b0;
      check("rnd_latency_in_bounds", 64'(lat >= 2 && lat <= SL + 2), 64'(1));
      if (!we) begin
        exp_rd = (32'(a) < CELLS) ? shadow[a] : '0;
        check("rnd_rdata", 64'(rd), 64'(exp_rd));
      end else if (32'(a) < CELLS) begin
        shadow[a] = wd;
      end
      @(negedge clk);
      check("rnd_ack_single_pulse", 64'(game_if.ack), 64'(0));
      next_cycle();

      // Coherence probe: a held valid lookup must show the current cell word.
      pa = $urandom_range(0, CELLS - 1);
      vga_active = 1'b1;
      vga_valid  = 1'b1;
      vga_addr   = 10'(pa);
      repeat (2) next_cycle();
      @(negedge clk);
      check("rnd_vga_coherent", 64'(vga_data), 64'(shadow[pa]));
      next_cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_board_ram_scheduler
